// File: rtl/e203_subsys_rst_seqr_if.sv
// Sequencer side-band bundle: pll lock, reset requests and ack, the three domain resets and status.
// The sequencer takes the slave modport; the SoC control side takes master.
interface e203_subsys_rst_seqr_if;
    logic       test_mode;
    logic       pll_lock;
    logic       sw_rst_req;
    logic       sw_rst_ack;
    logic       wdg_rst_req;
    logic       per_rst_n;
    logic       main_rst_n;
    logic       core_rst_n;
    logic [1:0] rst_cause;
    logic       seq_busy;

    modport master (
        output test_mode,
        output pll_lock,
        output sw_rst_req,
        output wdg_rst_req,
        input  sw_rst_ack,
        input  per_rst_n,
        input  main_rst_n,
        input  core_rst_n,
        input  rst_cause,
        input  seq_busy
    );

    modport slave (
        input  test_mode,
        input  pll_lock,
        input  sw_rst_req,
        input  wdg_rst_req,
        output sw_rst_ack,
        output per_rst_n,
        output main_rst_n,
        output core_rst_n,
        output rst_cause,
        output seq_busy
    );
endinterface

// File: rtl/e203_subsys_rst_seqr.sv
// Subsystem reset sequencer: waits for a stable PLL, then releases per -> main -> core GAP_CYC apart.
// All outputs registered (one edge after the decision); sw_rst_req is held by the requester until acked.
module e203_subsys_rst_seqr #(
    parameter int unsigned STABLE_CYC = 16,
    parameter int unsigned GAP_CYC    = 4,
    parameter int unsigned HOLD_CYC   = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    e203_subsys_rst_seqr_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_REL_PER   = 3'd2,
        ST_REL_MAIN  = 3'd3,
        ST_REL_CORE  = 3'd4,
        ST_RUN       = 3'd5,
        ST_HOLD      = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'b00,
        CAUSE_SW   = 2'b01,
        CAUSE_WDG  = 2'b10,
        CAUSE_LOCK = 2'b11
    } cause_e;

    // WAIT_LOCK compares against the full count; the dwell states leave on their last counted cycle.
    localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] GAP_LIM    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             per_rst_q, per_rst_d;
    logic             main_rst_q, main_rst_d;
    logic             core_rst_q, core_rst_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    cause_e           cause_q, cause_d;
    logic             go_hold;
    cause_e           hold_cause;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            per_rst_q  <= 1'b0;
            main_rst_q <= 1'b0;
            core_rst_q <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b1;
            cause_q    <= CAUSE_POR;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            per_rst_q  <= per_rst_d;
            main_rst_q <= main_rst_d;
            core_rst_q <= core_rst_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        per_rst_d  = per_rst_q;
        main_rst_d = main_rst_q;
        core_rst_d = core_rst_q;
        ack_d      = 1'b0;
        cause_d    = cause_q;
        go_hold    = 1'b0;
        hold_cause = cause_q;

        case (state_q)
            ST_ASSERT: begin
                per_rst_d  = 1'b0;
                main_rst_d = 1'b0;
                core_rst_d = 1'b0;
                cnt_d      = '0;
                state_d    = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!bus.pll_lock) begin
                    cnt_d = '0;
                end else if (cnt_q == STABLE_LIM) begin
                    cnt_d     = '0;
                    per_rst_d = 1'b1;
                    state_d   = ST_REL_PER;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REL_PER: begin
                if (!bus.pll_lock) begin
                    go_hold    = 1'b1;
                    hold_cause = CAUSE_LOCK;
                end else if (cnt_q == GAP_LIM) begin
                    cnt_d      = '0;
                    main_rst_d = 1'b1;
                    state_d    = ST_REL_MAIN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REL_MAIN: begin
                if (!bus.pll_lock) begin
                    go_hold    = 1'b1;
                    hold_cause = CAUSE_LOCK;
                end else if (cnt_q == GAP_LIM) begin
                    cnt_d      = '0;
                    core_rst_d = 1'b1;
                    state_d    = ST_REL_CORE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REL_CORE: begin
                if (!bus.pll_lock) begin
                    go_hold    = 1'b1;
                    hold_cause = CAUSE_LOCK;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Watchdog wins; a losing software request stays pending and is serviced on the next RUN.
                if (bus.wdg_rst_req) begin
                    go_hold    = 1'b1;
                    hold_cause = CAUSE_WDG;
                end else if (bus.sw_rst_req) begin
                    go_hold    = 1'b1;
                    hold_cause = CAUSE_SW;
                    ack_d      = 1'b1;
                end else if (!bus.pll_lock) begin
                    go_hold    = 1'b1;
                    hold_cause = CAUSE_LOCK;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LIM) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_ASSERT;
            end
        endcase

        if (go_hold) begin
            state_d    = ST_HOLD;
            cnt_d      = '0;
            per_rst_d  = 1'b0;
            main_rst_d = 1'b0;
            core_rst_d = 1'b0;
            cause_d    = hold_cause;
        end

        busy_d = (state_d != ST_RUN);
    end

    // Scan bypass is the only combinational path: the domains follow the raw reset pin.
    assign bus.per_rst_n  = bus.test_mode ? rst_n : per_rst_q;
    assign bus.main_rst_n = bus.test_mode ? rst_n : main_rst_q;
    assign bus.core_rst_n = bus.test_mode ? rst_n : core_rst_q;
    assign bus.sw_rst_ack = ack_q;
    assign bus.seq_busy   = busy_q;
    assign bus.rst_cause  = cause_q;

    a_ack_single: assert property (@(posedge clk) disable iff (!rst_n) ack_q |=> !ack_q);
    a_rel_order:  assert property (@(posedge clk) (!core_rst_q || main_rst_q) && (!main_rst_q || per_rst_q));

endmodule

// File: tb/tb_e203_subsys_rst_seqr.sv
// Bench for e203_subsys_rst_seqr: directed release-timing scenarios plus random traffic vs a timeline model.
module tb_e203_subsys_rst_seqr;
    localparam int STABLE = 16;
    localparam int GAP    = 4;
    localparam int HOLD   = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    e203_subsys_rst_seqr_if bus();

    e203_subsys_rst_seqr #(
        .STABLE_CYC(STABLE), .GAP_CYC(GAP), .HOLD_CYC(HOLD), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_ack = 0;

    // Timeline model: m_since counts edges since per release; main/core/run follow at fixed offsets.
    bit         m_boot      = 1'b1;
    int         m_hold_left = 0;
    bit         m_wait      = 1'b0;
    int         m_lockrun   = 0;
    int         m_since     = -1;
    logic [1:0] m_cause     = 2'b00;
    bit         m_ack       = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic m_enter_hold(input logic [1:0] c);
        m_since     = -1;
        m_hold_left = HOLD;
        m_cause     = c;
    endtask

    task automatic model_step();
        m_ack = 1'b0;
        if (!rst_n) begin
            m_boot = 1'b1; m_hold_left = 0; m_wait = 1'b0; m_since = -1; m_cause = 2'b00;
        end else if (m_boot) begin
            m_boot = 1'b0; m_wait = 1'b1; m_lockrun = 0;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_wait = 1'b1; m_lockrun = 0;
            end
        end else if (m_wait) begin
            if (!bus.pll_lock) m_lockrun = 0;
            else if (m_lockrun == STABLE) begin
                m_wait = 1'b0; m_since = 0;
            end else m_lockrun++;
        end else if (m_since <= 2*GAP) begin
            if (!bus.pll_lock) m_enter_hold(2'b11);
            else m_since++;
        end else if (bus.wdg_rst_req) begin
            m_enter_hold(2'b10);
        end else if (bus.sw_rst_req) begin
            m_enter_hold(2'b01);
            m_ack = 1'b1;
        end else if (!bus.pll_lock) begin
            m_enter_hold(2'b11);
        end
    endtask

    function automatic logic [2:0] rst_vec();
        return {bus.per_rst_n, bus.main_rst_n, bus.core_rst_n};
    endfunction

    task automatic check_all();
        logic [2:0] exp_r;
        if (bus.test_mode) exp_r = {3{rst_n}};
        else exp_r = {m_since >= 0, m_since >= GAP, m_since >= 2*GAP};
        chk("rst_vec", 32'(rst_vec()), 32'(exp_r));
        chk("ack", 32'(bus.sw_rst_ack), 32'(m_ack));
        chk("busy", 32'(bus.seq_busy), 32'(!(m_since > 2*GAP)));
        chk("cause", 32'(bus.rst_cause), 32'(m_cause));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_all();
        if (bus.sw_rst_ack) n_ack++;
        if (m_ack) bus.sw_rst_req = 1'b0;
    endtask

    // Edge numbers (cyc) at which per/main/core first read released and busy first reads low.
    task automatic seq_times(output int tp, output int tm, output int tc, output int tb);
        tp = -1; tm = -1; tc = -1; tb = -1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (tp < 0 && bus.per_rst_n)  tp = cyc;
            if (tm < 0 && bus.main_rst_n) tm = cyc;
            if (tc < 0 && bus.core_rst_n) tc = cyc;
            if (!bus.seq_busy) begin
                tb = cyc;
                break;
            end
        end
    endtask

    task automatic chk_times(input string tag, input int base);
        int tp, tm, tc, tb;
        seq_times(tp, tm, tc, tb);
        chk({tag, "_per"},  32'(tp), 32'(base));
        chk({tag, "_main"}, 32'(tm), 32'(base + GAP));
        chk({tag, "_core"}, 32'(tc), 32'(base + 2*GAP));
        chk({tag, "_run"},  32'(tb), 32'(base + 2*GAP + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.test_mode   = 1'b0;
        bus.pll_lock    = 1'b1;
        bus.sw_rst_req  = 1'b0;
        bus.wdg_rst_req = 1'b0;
        repeat (3) tick();
        chk("reset_state", 32'({rst_vec(), bus.sw_rst_ack, bus.seq_busy, bus.rst_cause}), 32'b000_0_1_00);

        // Power-on: per at edge 18, main 22, core 26, RUN 27.
        rst_n = 1'b1;
        cyc = 0;
        chk_times("por", STABLE + 2);
        chk("por_cause", 32'(bus.rst_cause), 32'd0);

        // One-cycle lock drop at count 10 restarts the stability window (+11 cycles).
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cyc = 0;
        repeat (11) tick();
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        chk_times("glitch", STABLE + 2 + 11);

        // Software reset from RUN.
        n_ack = 0;
        bus.sw_rst_req = 1'b1;
        tick();
        chk("sw_rst_low", 32'(rst_vec()), 32'd0);
        chk("sw_ack", 32'(bus.sw_rst_ack), 32'd1);
        chk("sw_cause", 32'(bus.rst_cause), 32'd1);
        cyc = 0;
        chk_times("sw_rel", HOLD + STABLE + 1);
        chk("sw_ack_cnt", 32'(n_ack), 32'd1);

        // Watchdog and software together: watchdog first, software serviced after re-release.
        n_ack = 0;
        bus.wdg_rst_req = 1'b1;
        bus.sw_rst_req  = 1'b1;
        tick();
        bus.wdg_rst_req = 1'b0;
        chk("wdg_cause", 32'(bus.rst_cause), 32'd2);
        chk("wdg_no_ack", 32'(bus.sw_rst_ack), 32'd0);
        cyc = 0;
        chk_times("wdg_rel", HOLD + STABLE + 1);
        tick();
        chk("pend_sw_ack", 32'(bus.sw_rst_ack), 32'd1);
        chk("pend_sw_cause", 32'(bus.rst_cause), 32'd1);
        cyc = 0;
        chk_times("pend_rel", HOLD + STABLE + 1);
        chk("pend_ack_cnt", 32'(n_ack), 32'd1);

        // Lock loss during REL_MAIN, then rst_n during HOLD.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cyc = 0;
        repeat (STABLE + 2 + GAP) tick();
        chk("in_rel_main", 32'(rst_vec()), 32'b110);
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        chk("lock_loss_rst", 32'(rst_vec()), 32'd0);
        chk("lock_loss_cause", 32'(bus.rst_cause), 32'd3);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("hold_abort_cause", 32'(bus.rst_cause), 32'd0);
        chk("hold_abort_busy", 32'(bus.seq_busy), 32'd1);

        // Scan bypass while the FSM sits in HOLD.
        cyc = 0;
        chk_times("tm_pre", STABLE + 2);
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        bus.test_mode = 1'b1;
        #1 chk("tm_hi", 32'(rst_vec()), 32'b111);
        rst_n = 1'b0;
        #1 chk("tm_lo", 32'(rst_vec()), 32'b000);
        rst_n = 1'b1;
        #1 chk("tm_back", 32'(rst_vec()), 32'b111);
        repeat (3) tick();
        bus.test_mode = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.wdg_rst_req = ($urandom_range(0, 119) == 0);
            if (!bus.sw_rst_req && $urandom_range(0, 79) == 0) bus.sw_rst_req = 1'b1;
            bus.pll_lock = ($urandom_range(0, 79) != 0);
            if (rst_n) rst_n = ($urandom_range(0, 499) != 0);
            else rst_n = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 149) == 0) bus.test_mode = ~bus.test_mode;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e203_subsys_rst_seqr.md
E203_SUBSYS_RST_SEQR -- requirements
Module: e203_subsys_rst_seqr

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 16: consecutive pll_lock-high cycles required before release.
REQ-002 SHALL have parameter GAP_CYC, default 4: cycles between successive domain releases.
REQ-003 SHALL have parameter HOLD_CYC, default 8: minimum reset-assert cycles for a requested reset.
REQ-004 SHALL have parameter CNT_W, default 8: sequencing counter width; every *_CYC value SHALL be in 1..2^CNT_W-1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 test_mode  input  1  scan/test bypass.
REQ-008 pll_lock  input  1  clock-stable indication, already synchronous to clk.
REQ-009 sw_rst_req  input  1  software reset request, level, held until sw_rst_ack.
REQ-010 sw_rst_ack  output  1  one-cycle pulse accepting sw_rst_req.
REQ-011 wdg_rst_req  input  1  watchdog reset request, single-cycle pulse.
REQ-012 per_rst_n  output  1  peripheral domain reset, active-low.
REQ-013 main_rst_n  output  1  bus/memory domain reset, active-low.
REQ-014 core_rst_n  output  1  core domain reset, active-low.
REQ-015 rst_cause  output  2  last reset cause: 00 power-on, 01 software, 10 watchdog, 11 lock loss.
REQ-016 seq_busy  output  1  high whenever state is not RUN.

Function
REQ-017 FSM states SHALL be ASSERT, WAIT_LOCK, REL_PER, REL_MAIN, REL_CORE, RUN, HOLD; state and outputs registered, no combinational input-to-output path except REQ-029.
REQ-018 ASSERT SHALL drive all three reset outputs low and go to WAIT_LOCK on the next edge.
REQ-019 WAIT_LOCK SHALL count consecutive pll_lock-high cycles; pll_lock low clears the count; reaching STABLE_CYC SHALL go to REL_PER.
REQ-020 Entering REL_PER SHALL set per_rst_n=1; after GAP_CYC cycles go to REL_MAIN, which sets main_rst_n=1; after GAP_CYC cycles go to REL_CORE, which sets core_rst_n=1 and goes to RUN on the next edge.
REQ-021 Release order SHALL be per, then main, then core; assertion of all three SHALL be simultaneous.
REQ-022 Counter SHALL clear on every state entry and never wrap.
REQ-023 In RUN, wdg_rst_req=1 SHALL go to HOLD with rst_cause=10; else sw_rst_req=1 SHALL go to HOLD with rst_cause=01 and pulse sw_rst_ack for exactly the cycle after the transition edge; else pll_lock=0 SHALL go to HOLD with rst_cause=11.
REQ-024 Simultaneous requests: priority wdg > sw > lock loss; a losing held sw_rst_req SHALL stay pending and not be acked.
REQ-025 Entering HOLD SHALL drive all reset outputs low on the transition edge; after HOLD_CYC cycles go to WAIT_LOCK.
REQ-026 In REL_PER, REL_MAIN, REL_CORE, pll_lock=0 SHALL go to HOLD with rst_cause=11.
REQ-027 wdg_rst_req and sw_rst_req SHALL be ignored outside RUN; sw_rst_req still high on RUN entry SHALL be serviced per REQ-023.
REQ-028 sw_rst_ack SHALL be 0 in all cycles except the REQ-023 pulse.
REQ-029 test_mode=1 SHALL force per_rst_n, main_rst_n, core_rst_n combinationally equal to rst_n; FSM keeps running.

Reset
REQ-030 rst_n=0 at a clock edge SHALL set state ASSERT, counter 0, per/main/core_rst_n=0, sw_rst_ack=0, seq_busy=1, rst_cause=00.
REQ-031 rst_n=0 mid-sequence or in HOLD SHALL abort the operation and apply REQ-030 on that edge.

Verification
REQ-032 Defaults, pll_lock=1, rst_n rises before edge 1 -> per_rst_n high after edge 18, main_rst_n after edge 22, core_rst_n after edge 26, seq_busy low from edge 27, rst_cause=00.
REQ-033 pll_lock dropped for 1 cycle at WAIT_LOCK count 10 -> count restarts; per_rst_n release delayed by 11 cycles vs REQ-032.
REQ-034 In RUN, sw_rst_req held high -> all resets low on next edge, sw_rst_ack one pulse, held 8 cycles, rerelease per REQ-032 spacing, rst_cause=01.
REQ-035 In RUN, wdg_rst_req and sw_rst_req high same cycle -> rst_cause=10, no ack; after re-release sw request serviced, rst_cause=01, one ack.
REQ-036 pll_lock low during REL_MAIN -> per/main_rst_n low next edge, HOLD, rst_cause=11; rst_n low during HOLD -> rst_cause=00, state ASSERT.
REQ-037 test_mode=1 with FSM in HOLD -> all three reset outputs track rst_n same cycle.
